// File: rtl/clk_div_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_pkg
//   Shared constants for the stopwatch clock-enable generator.
//   - CNT_W      : default counter/divisor width
//   - CLK_HZ     : nominal system clock frequency
//   - DIV_100HZ  : divisor giving a 100 Hz enable from CLK_HZ
//   - DIV_1KHZ   : divisor giving a 1 kHz enable from CLK_HZ
//   - MAX_NCH    : largest channel count the write port can address
//   - WR_CH_W    : width of the write-port channel select
//   - clog2()    : ceiling log2 for sizing derived fields
// ----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int CNT_W     = 20;
    localparam int CLK_HZ    = 100_000_000;
    localparam int DIV_100HZ = 1_000_000;
    localparam int DIV_1KHZ  = 100_000;
    localparam int MAX_NCH   = 8;
    localparam int WR_CH_W   = 3;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << result) < 64'(value)) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// ----------------------------------------------------------------------------
// clk_div_chan
//   One divider channel: a free-running counter that wraps every div_act
//   cycles, a one-cycle tick at each wrap and a near-50% square wave.
//   The divisor is double-buffered (div_shadow -> div_act) and only swapped
//   at a wrap or a restart, so a period is never cut short.
//
// Ports
//   clk       in   1       system clock
//   reset     in   1       synchronous, active-high reset
//   en        in   1       count enable; when low everything holds, tick = 0
//   sync_clr  in   1       restart: counter -> 0, reload divisor
//   ld        in   1       load ld_div into the shadow divisor
//   ld_div    in   CNT_W   new divisor (caller guarantees non-zero)
//   tick      out  1       one-cycle pulse, high in the cycle cnt reads 0
//   slow_clk  out  1       high ceil(div/2) cycles, low floor(div/2) cycles
// ----------------------------------------------------------------------------
module clk_div_chan #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_div,
    output logic             tick,
    output logic             slow_clk
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shadow;

    logic             wrap;
    logic [CNT_W-1:0] div_src;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] div_act_next;
    logic [CNT_W-1:0] hi_len;
    logic             tick_next;
    logic             slow_next;

    // A write landing in the same cycle as a wrap/restart must take effect
    // at that boundary, so the incoming value bypasses the shadow register.
    assign div_src = ld ? ld_div : div_shadow;

    // div_act is never 0, so div_act - 1 cannot underflow.
    assign wrap = en && (cnt == div_act - CNT_W'(1));

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        cnt_next     = cnt;
        div_act_next = div_act;
        tick_next    = 1'b0;
        slow_next    = slow_clk;

        if (sync_clr) begin
            // Restart beats both enable and a coincident wrap: no tick.
            cnt_next     = '0;
            div_act_next = div_src;
        end else if (wrap) begin
            cnt_next     = '0;
            div_act_next = div_src;
            tick_next    = 1'b1;
        end else if (en) begin
            cnt_next = cnt + CNT_W'(1);
        end

        // (div + 1) >> 1 written so it cannot overflow at the maximum divisor.
        // Uses the divisor that will be active next cycle so the first phase
        // after a reload already has the new length.
        hi_len = (div_act_next >> 1) + {{(CNT_W-1){1'b0}}, div_act_next[0]};

        if (sync_clr) begin
            slow_next = 1'b1;
        end else if (en) begin
            slow_next = (cnt_next < hi_len);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register in this block samples pre-edge values.
        if (reset) begin
            cnt        <= '0;
            div_act    <= DIV_RST;
            div_shadow <= DIV_RST;
            tick       <= 1'b0;
            slow_clk   <= 1'b1;
        end else begin
            cnt      <= cnt_next;
            div_act  <= div_act_next;
            tick     <= tick_next;
            slow_clk <= slow_next;
            if (ld) begin
                div_shadow <= ld_div;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// ----------------------------------------------------------------------------
// clk_div_multi
//   Multi-channel, run-time-programmable clock-enable generator for the
//   stopwatch. Each channel divides clk by its own divisor and produces a
//   one-cycle tick and a near-50% square wave. A single write port updates
//   one channel's pending divisor per cycle; the new value takes effect at
//   that channel's next wrap or restart.
//
// Parameters
//   NCH       number of independent channels (1..8)
//   CNT_W     counter/divisor width
//   DIV_INIT  packed reset divisors, channel 0 in the LSBs
//
// Ports
//   clk       in   1       system clock
//   reset     in   1       synchronous, active-high reset
//   en        in   NCH     per-channel count enable
//   sync_clr  in   NCH     per-channel restart
//   wr_en     in   1       divisor write strobe
//   wr_ch     in   3       target channel of the write
//   wr_div    in   CNT_W   new divisor (legal 1..2^CNT_W-1)
//   wr_ack    out  1       one-cycle pulse: write accepted
//   wr_err    out  1       one-cycle pulse: write rejected
//   tick      out  NCH     one-cycle enable pulse per channel period
//   slow_clk  out  NCH     square wave per channel
// ----------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int                   NCH      = 2,
    parameter int                   CNT_W    = 20,
    parameter logic [NCH*CNT_W-1:0] DIV_INIT = {20'd100000, 20'd1000000}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     en,
    input  logic [NCH-1:0]     sync_clr,
    input  logic               wr_en,
    input  logic [WR_CH_W-1:0] wr_ch,
    input  logic [CNT_W-1:0]   wr_div,
    output logic               wr_ack,
    output logic               wr_err,
    output logic [NCH-1:0]     tick,
    output logic [NCH-1:0]     slow_clk
);

    // Channel limit widened by one bit so NCH = 8 is representable.
    localparam logic [WR_CH_W:0] NCH_LIM = (WR_CH_W+1)'(NCH);

    logic           ch_ok;
    logic           wr_accept;
    logic [NCH-1:0] ld;

    // A write is legal only for an existing channel and a non-zero divisor;
    // anything else is rejected without touching channel state.
    assign ch_ok     = ({1'b0, wr_ch} < NCH_LIM);
    assign wr_accept = wr_en && ch_ok && (wr_div != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_accept;
            wr_err <= wr_en && !wr_accept;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign ld[i] = wr_accept && (wr_ch == WR_CH_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .en       (en[i]),
            .sync_clr (sync_clr[i]),
            .ld       (ld[i]),
            .ld_div   (wr_div),
            .tick     (tick[i]),
            .slow_clk (slow_clk[i])
        );
    end

endmodule
